// File: rtl/ram32_bridge_pkg.sv
// rtl/ram32_bridge_pkg.sv - shared types and constants for the RAM32 bus bridge
package ram32_bridge_pkg;

   localparam int RAM_WORDS = 32;
   localparam int BYTE_AW   = 7;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   typedef enum logic [1:0] {NONE, EXT, DBUS, IBUS} grant_t;

   // Loader writes touch exactly one byte lane of the addressed word.
   function automatic logic [3:0] lane_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/ram32_bus_bridge_if.sv
// rtl/ram32_bus_bridge_if.sv - loader, ibus, dbus and RAM32 port signals of the bridge
interface ram32_bus_bridge_if;

   logic        ext_valid;
   logic        ext_we;
   logic [6:0]  ext_addr;
   logic [7:0]  ext_wdata;
   logic        ext_ready;
   logic        ext_rvalid;
   logic [7:0]  ext_rdata;

   logic        ibus_cyc;
   logic [31:0] ibus_adr;
   logic [31:0] ibus_rdt;
   logic        ibus_ack;

   logic        dbus_cyc;
   logic [31:0] dbus_adr;
   logic        dbus_we;
   logic [31:0] dbus_dat;
   logic [3:0]  dbus_sel;
   logic [31:0] dbus_rdt;
   logic        dbus_ack;

   logic        ram_en;
   logic [4:0]  ram_a;
   logic [3:0]  ram_we;
   logic [31:0] ram_di;
   logic [31:0] ram_do;

   modport slave (
      input  ext_valid, ext_we, ext_addr, ext_wdata,
      input  ibus_cyc, ibus_adr,
      input  dbus_cyc, dbus_adr, dbus_we, dbus_dat, dbus_sel,
      input  ram_do,
      output ext_ready, ext_rvalid, ext_rdata,
      output ibus_rdt, ibus_ack,
      output dbus_rdt, dbus_ack,
      output ram_en, ram_a, ram_we, ram_di
   );

   modport master (
      output ext_valid, ext_we, ext_addr, ext_wdata,
      output ibus_cyc, ibus_adr,
      output dbus_cyc, dbus_adr, dbus_we, dbus_dat, dbus_sel,
      output ram_do,
      input  ext_ready, ext_rvalid, ext_rdata,
      input  ibus_rdt, ibus_ack,
      input  dbus_rdt, dbus_ack,
      input  ram_en, ram_a, ram_we, ram_di
   );

endinterface

// File: rtl/ram32_arb_prio.sv
// rtl/ram32_arb_prio.sv - fixed-priority requester select: ext over dbus over ibus
module ram32_arb_prio
   import ram32_bridge_pkg::*;
(
   input  logic   ext_valid,
   input  logic   dbus_cyc,
   input  logic   ibus_cyc,
   output grant_t grant
);

   always_comb begin
      grant = NONE;
      if (ext_valid)
         grant = EXT;
      else if (dbus_cyc)
         grant = DBUS;
      else if (ibus_cyc)
         grant = IBUS;
   end

endmodule

// File: rtl/ram32_bus_bridge.sv
// rtl/ram32_bus_bridge.sv - arbitrates loader, ibus and dbus onto the single RAM32 port
module ram32_bus_bridge
   import ram32_bridge_pkg::*;
#(
   parameter int AW      = 5,
   parameter int BYTE_AW = 7
) (
   input logic               clk,
   input logic               rst_n,
   ram32_bus_bridge_if.slave bus
);

   state_t          state_q, state_d;
   grant_t          gnt_q, arb_gnt;
   logic            ext_wr_q;
   logic [AW-1:0]   addr_q;
   logic [3:0]      we_q;
   logic [31:0]     di_q;
   logic [1:0]      byte_q;

   logic            ram_en_c;
   logic [3:0]      ram_we_c;
   logic            ext_ready_c, ext_rvalid_c, dbus_ack_c, ibus_ack_c;
   logic            unused_adr;

   ram32_arb_prio u_arb (
      .ext_valid (bus.ext_valid),
      .dbus_cyc  (bus.dbus_cyc),
      .ibus_cyc  (bus.ibus_cyc),
      .grant     (arb_gnt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt_q    <= NONE;
         ext_wr_q <= 1'b0;
         addr_q   <= '0;
         we_q     <= '0;
         di_q     <= '0;
         byte_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) begin
            gnt_q <= arb_gnt;
            case (arb_gnt)
               EXT: begin
                  addr_q   <= bus.ext_addr[BYTE_AW-1:2];
                  we_q     <= bus.ext_we ? lane_onehot(bus.ext_addr[1:0]) : 4'b0000;
                  di_q     <= {4{bus.ext_wdata}};
                  byte_q   <= bus.ext_addr[1:0];
                  ext_wr_q <= bus.ext_we;
               end
               DBUS: begin
                  addr_q   <= bus.dbus_adr[BYTE_AW-1:2];
                  we_q     <= bus.dbus_we ? bus.dbus_sel : 4'b0000;
                  di_q     <= bus.dbus_dat;
                  ext_wr_q <= 1'b0;
               end
               IBUS: begin
                  addr_q   <= bus.ibus_adr[BYTE_AW-1:2];
                  we_q     <= 4'b0000;
                  ext_wr_q <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ram_en_c     = 1'b0;
      ram_we_c     = 4'b0000;
      ext_ready_c  = 1'b0;
      ext_rvalid_c = 1'b0;
      dbus_ack_c   = 1'b0;
      ibus_ack_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_gnt != NONE) begin
               state_d     = ISSUE;
               ext_ready_c = (arb_gnt == EXT);
            end
         end
         ISSUE: begin
            ram_en_c = 1'b1;
            ram_we_c = we_q;
            state_d  = RESP;
         end
         RESP: begin
            state_d = IDLE;
            case (gnt_q)
               EXT:     ext_rvalid_c = !ext_wr_q;
               DBUS:    dbus_ack_c   = 1'b1;
               IBUS:    ibus_ack_c   = 1'b1;
               default: ;
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   // Gating with rst_n keeps a reset edge from also being a RAM write edge or an ack.
   assign bus.ram_en     = ram_en_c & rst_n;
   assign bus.ram_we     = ram_we_c & {4{rst_n}};
   assign bus.ext_ready  = ext_ready_c & rst_n;
   assign bus.ext_rvalid = ext_rvalid_c & rst_n;
   assign bus.dbus_ack   = dbus_ack_c & rst_n;
   assign bus.ibus_ack   = ibus_ack_c & rst_n;

   assign bus.ram_a     = addr_q;
   assign bus.ram_di    = di_q;
   assign bus.ibus_rdt  = bus.ram_do;
   assign bus.dbus_rdt  = bus.ram_do;
   assign bus.ext_rdata = 8'(bus.ram_do >> {byte_q, 3'b000});

   assign unused_adr = &{1'b0, bus.ibus_adr[31:BYTE_AW], bus.ibus_adr[1:0],
                         bus.dbus_adr[31:BYTE_AW], bus.dbus_adr[1:0]};

endmodule

// File: tb/tb_ram32_bus_bridge.sv
// tb/tb_ram32_bus_bridge.sv - scoreboard bench for ram32_bus_bridge with a RAM32 model
module tb_ram32_bus_bridge;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic init_mem = 1'b0;
   always #5 clk = ~clk;

   ram32_bus_bridge_if bif ();

   ram32_bus_bridge dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   logic [31:0] mem [32];

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
         mem[3] <= 32'hDEADBEEF;
      end else if (bif.ram_en) begin
         bif.ram_do <= mem[bif.ram_a];
         for (int l = 0; l < 4; l++)
            if (bif.ram_we[l]) mem[bif.ram_a][l*8 +: 8] <= bif.ram_di[l*8 +: 8];
      end
   end

   int checks = 0;
   int failures = 0;
   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {int kind; logic [31:0] data; bit chk_data; int due;} resp_t;
   typedef struct {logic [4:0] a; logic [3:0] we; logic [31:0] di;} ram_t;
   resp_t resp_q[$];
   ram_t  ram_q[$];

   function automatic void exp_resp(input int kind, input logic [31:0] data, input bit cd, input int due);
      resp_t r;
      r.kind = kind; r.data = data; r.chk_data = cd; r.due = due;
      resp_q.push_back(r);
   endfunction

   function automatic void exp_ram(input logic [4:0] a, input logic [3:0] we, input logic [31:0] di);
      ram_t m;
      m.a = a; m.we = we; m.di = di;
      ram_q.push_back(m);
   endfunction

   int          mon_n, mon_kind;
   logic [31:0] mon_data;
   resp_t       mon_r;
   ram_t        mon_m;

   always @(negedge clk) begin
      mon_n = int'(bif.ext_rvalid) + int'(bif.dbus_ack) + int'(bif.ibus_ack);
      if (mon_n > 1) chk("one_completion", mon_n, 1);
      if (mon_n == 1) begin
         mon_kind = bif.ext_rvalid ? 0 : (bif.dbus_ack ? 1 : 2);
         mon_data = (mon_kind == 0) ? {24'h0, bif.ext_rdata} :
                    (mon_kind == 1) ? bif.dbus_rdt : bif.ibus_rdt;
         if (resp_q.size() == 0) begin
            chk("unexpected_completion", mon_n, 0);
         end else begin
            mon_r = resp_q.pop_front();
            chk("resp_kind", mon_kind, mon_r.kind);
            chk("resp_cycle", cyc_cnt, mon_r.due);
            if (mon_r.chk_data) chk("resp_data", mon_data, mon_r.data);
         end
      end
      if (bif.ram_en) begin
         if (ram_q.size() == 0) begin
            chk("unexpected_ram_access", {31'h0, bif.ram_en}, 0);
         end else begin
            mon_m = ram_q.pop_front();
            chk("ram_a", {27'h0, bif.ram_a}, {27'h0, mon_m.a});
            chk("ram_we", {28'h0, bif.ram_we}, {28'h0, mon_m.we});
            if (mon_m.we != 0) chk("ram_di", bif.ram_di, mon_m.di);
         end
      end else if (bif.ram_we != 0) begin
         chk("ram_we_outside_issue", {28'h0, bif.ram_we}, 0);
      end
   end

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic ext_op(input logic we, input logic [6:0] addr, input logic [7:0] wdata);
      bit got = 0;
      bif.ext_valid = 1'b1; bif.ext_we = we; bif.ext_addr = addr; bif.ext_wdata = wdata;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bif.ext_ready) got = 1;
      end
      chk("ext_ready_seen", {31'h0, got}, 1);
      @(posedge clk); #1;
      bif.ext_valid = 1'b0;
   endtask

   task automatic dbus_op(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      bit got = 0;
      bif.dbus_cyc = 1'b1; bif.dbus_we = we; bif.dbus_adr = adr; bif.dbus_dat = dat; bif.dbus_sel = sel;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bif.dbus_ack) got = 1;
      end
      chk("dbus_ack_seen", {31'h0, got}, 1);
      @(posedge clk); #1;
      bif.dbus_cyc = 1'b0;
   endtask

   task automatic ibus_op(input logic [31:0] adr);
      bit got = 0;
      bif.ibus_cyc = 1'b1; bif.ibus_adr = adr;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bif.ibus_ack) got = 1;
      end
      chk("ibus_ack_seen", {31'h0, got}, 1);
      @(posedge clk); #1;
      bif.ibus_cyc = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d required=<20000 cycles", cyc_cnt);
      $fatal(1, "timeout");
   end

   initial begin
      bit got;
      int s;
      bif.ext_valid = 1'b1; bif.ext_we = 1'b0; bif.ext_addr = 7'h0; bif.ext_wdata = 8'h0;
      bif.ibus_cyc = 1'b0; bif.ibus_adr = 32'h0;
      bif.dbus_cyc = 1'b1; bif.dbus_we = 1'b0; bif.dbus_adr = 32'h0; bif.dbus_dat = 32'h0; bif.dbus_sel = 4'h0;
      rst_n = 1'b0;
      init_mem = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      init_mem = 1'b0;

      // Requests are held during reset; nothing may be granted or driven.
      @(negedge clk);
      chk("rst_ram_en", {31'h0, bif.ram_en}, 0);
      chk("rst_ram_we", {28'h0, bif.ram_we}, 0);
      chk("rst_ext_ready", {31'h0, bif.ext_ready}, 0);
      chk("rst_ext_rvalid", {31'h0, bif.ext_rvalid}, 0);
      chk("rst_dbus_ack", {31'h0, bif.dbus_ack}, 0);
      chk("rst_ibus_ack", {31'h0, bif.ibus_ack}, 0);
      chk("rst_ram_a", {27'h0, bif.ram_a}, 0);
      chk("rst_ram_di", bif.ram_di, 0);

      @(posedge clk); #1;
      bif.ext_valid = 1'b0; bif.dbus_cyc = 1'b0;
      rst_n = 1'b1;

      // First grant in the first cycle out of reset.
      exp_ram(5'd3, 4'b0000, 32'h0);
      exp_resp(2, 32'hDEADBEEF, 1, cyc_cnt + 2);
      ibus_op(32'h0000_000C);
      settle();

      exp_ram(5'd3, 4'b0010, 32'h13131313);
      ext_op(1'b1, 7'h0D, 8'h13);
      settle();

      exp_ram(5'd3, 4'b0000, 32'h0);
      exp_resp(0, 32'h13, 1, cyc_cnt + 2);
      ext_op(1'b0, 7'h0D, 8'h00);
      settle();

      exp_ram(5'd3, 4'b0000, 32'h0);
      exp_resp(0, 32'hAD, 1, cyc_cnt + 2);
      ext_op(1'b0, 7'h0E, 8'h00);
      settle();

      exp_ram(5'd4, 4'b0101, 32'hAABBCCDD);
      exp_resp(1, 32'h0, 0, cyc_cnt + 2);
      dbus_op(1'b1, 32'h0000_0010, 32'hAABBCCDD, 4'b0101);
      settle();

      exp_ram(5'd4, 4'b0000, 32'h0);
      exp_resp(1, 32'h00BB00DD, 1, cyc_cnt + 2);
      dbus_op(1'b0, 32'h0000_0010, 32'h0, 4'b1111);
      settle();

      exp_ram(5'd1, 4'b1111, 32'h12345678);
      exp_resp(1, 32'h0, 0, cyc_cnt + 2);
      dbus_op(1'b1, 32'hFFFF_FF84, 32'h12345678, 4'b1111);
      settle();

      exp_ram(5'd4, 4'b0000, 32'h0);
      exp_resp(1, 32'h0, 0, cyc_cnt + 2);
      dbus_op(1'b1, 32'h0000_0010, 32'hFFFFFFFF, 4'b0000);
      settle();

      exp_ram(5'd4, 4'b0000, 32'h0);
      exp_resp(1, 32'h00BB00DD, 1, cyc_cnt + 2);
      dbus_op(1'b0, 32'h0000_0010, 32'h0, 4'b1111);
      settle();

      exp_ram(5'd1, 4'b0000, 32'h0);
      exp_resp(2, 32'h12345678, 1, cyc_cnt + 2);
      ibus_op(32'h0000_0004);
      settle();

      // All three requesters in the same cycle.
      s = cyc_cnt;
      exp_ram(5'd4, 4'b0000, 32'h0);
      exp_ram(5'd1, 4'b0000, 32'h0);
      exp_ram(5'd3, 4'b0000, 32'h0);
      exp_resp(0, 32'hDD, 1, s + 2);
      exp_resp(1, 32'h12345678, 1, s + 5);
      exp_resp(2, 32'hDEAD13EF, 1, s + 8);
      fork
         ext_op(1'b0, 7'h10, 8'h00);
         dbus_op(1'b0, 32'h0000_0004, 32'h0, 4'b1111);
         ibus_op(32'h0000_000C);
      join
      settle();

      // Reset lands in the ISSUE cycle of a dbus write; the held request is re-issued.
      bif.dbus_cyc = 1'b1; bif.dbus_we = 1'b1; bif.dbus_adr = 32'h0000_0008;
      bif.dbus_dat = 32'hCAFEF00D; bif.dbus_sel = 4'b1111;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_ram_we", {28'h0, bif.ram_we}, 0);
      chk("abort_ram_en", {31'h0, bif.ram_en}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_ram(5'd2, 4'b1111, 32'hCAFEF00D);
      exp_resp(1, 32'h0, 0, cyc_cnt + 2);
      @(negedge clk);
      chk("abort_no_write", mem[2], 32'h0);
      chk("abort_idle_ram_en", {31'h0, bif.ram_en}, 0);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (bif.dbus_ack) got = 1;
         else @(negedge clk);
      end
      chk("reissue_ack_seen", {31'h0, got}, 1);
      @(posedge clk); #1;
      bif.dbus_cyc = 1'b0;
      settle();

      exp_ram(5'd2, 4'b0000, 32'h0);
      exp_resp(1, 32'hCAFEF00D, 1, cyc_cnt + 2);
      dbus_op(1'b0, 32'h0000_0008, 32'h0, 4'b1111);
      settle();

      for (int i = 0; i < 20 && (resp_q.size() != 0 || ram_q.size() != 0); i++) @(posedge clk);
      chk("resp_queue_drained", resp_q.size(), 0);
      chk("ram_queue_drained", ram_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
